rgb_led_pwm: RTL and testbench



---
 rtl/rgb_led_pwm_pkg.sv | 17 +
 rtl/rgb_led_pwm_channel.sv | 29 ++
 rtl/rgb_led_pwm.sv | 79 +++++++
 tb/tb_rgb_led_pwm.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rgb_led_pwm_pkg.sv
// rgb_led_pwm_pkg: register map, mode fields and LED polarity helper for rgb_led_pwm
package rgb_led_pwm_pkg;
  localparam logic [1:0] ADDR_DUTY_R = 2'd0;
  localparam logic [1:0] ADDR_DUTY_G = 2'd1;
  localparam logic [1:0] ADDR_DUTY_B = 2'd2;
  localparam logic [1:0] ADDR_MODE = 2'd3;
  localparam int MODE_BREATHE = 0;
  localparam int MODE_SPEED_LSB = 4;
  localparam int MODE_SPEED_MSB = 7;
  typedef struct packed {
    logic [3:0] speed;
    logic breathe;
  } mode_t;
  function automatic logic [2:0] led_off(input bit active_low);
    return active_low ? 3'b111 : 3'b000;
  endfunction
endpackage

// File: rtl/rgb_led_pwm_channel.sv
// pwm_channel: one colour's pending/active duty, breathe scaling and step compare
module pwm_channel (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       load,
  input  logic       breathe,
  input  logic [7:0] env,
  input  logic [7:0] step,
  output logic       lit
);
  logic [7:0] pending, active, duty;
  logic [15:0] prod;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      active <= '0;
    end else begin
      if (wr_en) pending <= wr_data;
      if (load) active <= pending;
    end
  end
  always_comb begin
    prod = active * env;
    duty = breathe ? prod[15:8] : active;
    lit = (duty == 8'hff) | (step < duty);
  end
endmodule

// File: rtl/rgb_led_pwm.sv
// rgb_led_pwm: three-channel 8-bit PWM LED driver with breathing envelope and boundary-synchronous updates
module rgb_led_pwm
  import rgb_led_pwm_pkg::*;
#(
  parameter int PRESCALE = 94,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       CLOCK_24,
  input  logic       resetN,
  input  logic [2:0] gpio_en,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [2:0] RGB_LED
);
  logic [15:0] pre;
  logic [7:0] step, env;
  logic [3:0] pcnt;
  logic up, tick, boundary, wr;
  logic [2:0] lit;
  mode_t mode_p, mode_a;
  always_comb begin
    tick = pre == 16'(PRESCALE - 1);
    boundary = tick & (step == 8'hff);
    wr = wr_valid & wr_ready;
  end
  always_ff @(posedge CLOCK_24 or negedge resetN) begin
    if (!resetN) begin
      wr_ready <= 1'b0;
      pre <= '0;
      step <= '0;
      env <= '0;
      up <= 1'b1;
      pcnt <= '0;
      mode_p <= '0;
      mode_a <= '0;
      RGB_LED <= led_off(ACTIVE_LOW);
    end else begin
      wr_ready <= 1'b1;
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) step <= step + 1'b1;
      if (wr && wr_addr == ADDR_MODE)
        mode_p <= '{speed: wr_data[MODE_SPEED_MSB:MODE_SPEED_LSB], breathe: wr_data[MODE_BREATHE]};
      if (boundary) mode_a <= mode_p;
      if (!mode_a.breathe) begin
        env <= 8'hff;
        up <= 1'b1;
        pcnt <= '0;
      end else if (boundary) begin
        if (pcnt != mode_a.speed) pcnt <= pcnt + 1'b1;
        else begin
          pcnt <= '0;
          if (up) begin
            if (env == 8'hff) up <= 1'b0;
            else env <= env + 1'b1;
          end else begin
            if (env == 8'h00) up <= 1'b1;
            else env <= env - 1'b1;
          end
        end
      end
      RGB_LED <= ACTIVE_LOW ? ~(lit & gpio_en) : lit & gpio_en;
    end
  end
  for (genvar i = 0; i < 3; i++) begin : g_ch
    pwm_channel u_ch (
      .clk(CLOCK_24),
      .rst_n(resetN),
      .wr_en(wr && wr_addr == ADDR_DUTY_R + 2'(i)),
      .wr_data(wr_data),
      .load(boundary),
      .breathe(mode_a.breathe),
      .env(env),
      .step(step),
      .lit(lit[i])
    );
  end
endmodule

// File: tb/tb_rgb_led_pwm.sv
// tb_rgb_led_pwm: directed and randomized checks of rgb_led_pwm against a period-level on-time model
module tb_rgb_led_pwm;
  logic clk = 1'b0, rst_n = 1'b1, wr_valid = 1'b0;
  logic [2:0] gpio_en = 3'b000;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic wr_ready;
  logic [2:0] rgb;
  int checks = 0, errors = 0;
  int k;
  int got_low[3], exp_low[3], pdut[3], adut[3];
  int pmode, amode, e, pc;
  bit up;
  always #5 clk = ~clk;
  rgb_led_pwm #(.PRESCALE(1), .ACTIVE_LOW(1'b1)) dut (
    .CLOCK_24(clk),
    .resetN(rst_n),
    .gpio_en(gpio_en),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .RGB_LED(rgb)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int on_len(int i);
    int d;
    d = (amode & 1) ? (adut[i] * e) >> 8 : adut[i];
    return d == 255 ? 256 : d;
  endfunction
  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 3; i++) begin
      got_low[i] = 0;
      exp_low[i] = 0;
      pdut[i] = 0;
      adut[i] = 0;
    end
    pmode = 0;
    amode = 0;
    e = 255;
    up = 1;
    pc = 0;
  endtask
  task automatic tick();
    logic [2:0] en;
    int s;
    @(posedge clk);
    en = gpio_en;
    s = k % 256;
    k++;
    for (int i = 0; i < 3; i++) if (en[i] && s < on_len(i)) exp_low[i]++;
    #1;
    for (int i = 0; i < 3; i++) if (!rgb[i]) got_low[i]++;
    if (k % 256 == 0) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("period%0d_ch%0d_low", k / 256 - 1, i), got_low[i], exp_low[i]);
        got_low[i] = 0;
        exp_low[i] = 0;
      end
      if (!(amode & 1)) begin
        e = 255;
        up = 1;
        pc = 0;
      end else if (pc == (amode >> 4)) begin
        pc = 0;
        if (up) begin
          if (e == 255) up = 0;
          else e++;
        end else begin
          if (e == 0) up = 1;
          else e--;
        end
      end else pc++;
      for (int i = 0; i < 3; i++) adut[i] = pdut[i];
      amode = pmode;
    end
  endtask
  task automatic wr(int a, int d);
    wr_valid = 1'b1;
    wr_addr = a[1:0];
    wr_data = d[7:0];
    tick();
    wr_valid = 1'b0;
    if (a == 3) pmode = d & 'hF1;
    else pdut[a] = d;
  endtask
  task automatic go_to(int s);
    while (k % 256 != s) tick();
  endtask
  task automatic periods(int n);
    go_to(0);
    repeat (n) begin
      tick();
      go_to(0);
    end
  endtask
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    check("reset_async_rgb", rgb, 3'b111);
    check("reset_ready_low", wr_ready, 1'b0);
    model_reset();
    @(posedge clk);
    #1 check("reset_hold_rgb", rgb, 3'b111);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", wr_ready, 1'b0);
  endtask
  initial begin
    do_reset();
    tick();
    check("ready_after_edge", wr_ready, 1'b1);
    wr(0, 64);
    gpio_en = 3'b001;
    periods(2);
    wr(1, 255);
    wr(2, 0);
    gpio_en = 3'b110;
    periods(2);
    gpio_en = 3'b001;
    wr(0, 10);
    periods(1);
    go_to(255);
    wr(0, 200);
    periods(2);
    wr(0, 1);
    wr(0, 77);
    periods(2);
    wr(0, 128);
    periods(1);
    repeat (50) tick();
    gpio_en = 3'b000;
    check("en_clear_same_cycle", rgb[0], 1'b0);
    tick();
    check("en_clear_next_cycle", rgb[0], 1'b1);
    gpio_en = 3'b001;
    periods(2);
    wr(2, 255);
    wr(3, 'h01);
    gpio_en = 3'b100;
    periods(12);
    wr(3, 'h2F);
    periods(12);
    wr(3, 'h0E);
    periods(3);
    for (int it = 0; it < 30; it++) begin
      gpio_en = 3'($urandom);
      do begin
        if ($urandom_range(0, 31) == 0)
          wr($urandom_range(0, 3), $urandom_range(0, 3) == 0 ? 255 : $urandom_range(0, 255));
        else tick();
      end while (k % 256 != 0);
    end
    wr(3, 0);
    wr(0, 200);
    gpio_en = 3'b001;
    periods(2);
    repeat (20) tick();
    check("lit_before_reset", rgb[0], 1'b0);
    do_reset();
    tick();
    check("ready_after_reset", wr_ready, 1'b1);
    periods(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
